// File: rtl/dmem_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter: FSM state encoding,
// requester port identifiers and the default memory size.
package dmem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam int DEF_MEM_BYTES = 8192;

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle between the fetch/memory stages, the arbiter and the memory array.
// slave  : the arbiter's view (takes requests, drives the memory port)
// master : the surrounding system's view (requesters plus memory array)
interface dmem_port_arbiter_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ack;
    logic [DATA_W-1:0] i_rdata;
    logic              i_err;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;
    logic              d_err;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
        output mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
        input  mem_en, mem_we, mem_addr, mem_wdata, busy
    );

endinterface

// File: rtl/dmem_port_arbiter_pick.sv
// Winner selection for the shared memory port. The D-port wins by default;
// after STARVE_MAX consecutive D grants over a waiting fetch, fetch wins once.
module dmem_arb_pick
    import dmem_port_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_req_i,
    input  logic d_req_i,
    input  logic grant_i,
    output logic port_o
);
    localparam int              CNT_W   = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_q;
    logic [CNT_W-1:0] starve_d;
    logic             win_d_s;

    // Pick the winner and compute the next starvation count for this grant.
    always_comb begin
        win_d_s  = 1'b0;
        starve_d = starve_q;
        if (d_req_i && (!i_req_i || (starve_q < CNT_MAX))) begin
            win_d_s = 1'b1;
        end else begin
            win_d_s = 1'b0;
        end
        if (grant_i) begin
            if (!win_d_s) begin
                starve_d = '0;
            end else if (i_req_i && (starve_q < CNT_MAX)) begin
                starve_d = starve_q + CNT_W'(1);
            end else begin
                starve_d = starve_q;
            end
        end else begin
            starve_d = starve_q;
        end
    end

    assign port_o = win_d_s ? PORT_D : PORT_I;

    // Starvation counter only moves on an actual grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data memory between the fetch I-port and the
// memory-stage D-port: one access at a time, fixed read latency, one-cycle
// acknowledge with data/error back to the winner. All outputs are flops.
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int DATA_W     = 64,
    parameter int ADDR_W     = 64,
    parameter int MEM_BYTES  = DEF_MEM_BYTES,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    dmem_port_arbiter_if.slave bus
);
    localparam logic [ADDR_W:0] ACC_BYTES = (ADDR_W + 1)'(DATA_W / 8);
    localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W + 1)'(MEM_BYTES);

    arb_state_e        state_q;
    logic              port_q;
    logic              we_q;
    logic [3:0]        wait_cnt_q;
    logic              mem_en_q, mem_we_q, busy_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q, i_rdata_q, d_rdata_q;
    logic              i_ack_q, d_ack_q, i_err_q, d_err_q;

    logic              grant_s;
    logic              port_s;
    logic              sel_we_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;
    logic [ADDR_W:0]   acc_end_s;
    logic              addr_err_s;

    assign grant_s = (state_q == ST_IDLE) && (bus.i_req || bus.d_req);

    dmem_arb_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_req_i (bus.i_req),
        .d_req_i (bus.d_req),
        .grant_i (grant_s),
        .port_o  (port_s)
    );

    // Mux the winner's request and bound-check it one bit wider so it cannot wrap.
    always_comb begin
        sel_addr_s  = '0;
        sel_wdata_s = '0;
        sel_we_s    = 1'b0;
        if (port_s == PORT_D) begin
            sel_addr_s  = bus.d_addr;
            sel_wdata_s = bus.d_wdata;
            sel_we_s    = bus.d_we;
        end else begin
            sel_addr_s  = bus.i_addr;
            sel_wdata_s = '0;
            sel_we_s    = 1'b0;
        end
        acc_end_s  = {1'b0, sel_addr_s} + ACC_BYTES;
        addr_err_s = (acc_end_s > MEM_LIMIT);
    end

    // Access sequencer: IDLE -> ISSUE -> WAIT -> RESP, or IDLE -> RESP on error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            port_q      <= PORT_I;
            we_q        <= 1'b0;
            wait_cnt_q  <= 4'd0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            i_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            i_err_q     <= 1'b0;
            d_err_q     <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            mem_en_q  <= 1'b0;
            mem_we_q  <= 1'b0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            i_err_q   <= 1'b0;
            d_err_q   <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (grant_s) begin
                        port_q      <= port_s;
                        we_q        <= sel_we_s;
                        mem_addr_q  <= sel_addr_s;
                        mem_wdata_q <= sel_wdata_s;
                        busy_q      <= 1'b1;
                        if (addr_err_s) begin
                            state_q <= ST_RESP;
                            if (port_s == PORT_D) begin
                                d_ack_q <= 1'b1;
                                d_err_q <= 1'b1;
                            end else begin
                                i_ack_q <= 1'b1;
                                i_err_q <= 1'b1;
                            end
                        end else begin
                            state_q  <= ST_ISSUE;
                            mem_en_q <= 1'b1;
                            mem_we_q <= sel_we_s;
                        end
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    state_q    <= ST_WAIT;
                    wait_cnt_q <= 4'(MEM_LAT - 1);
                end
                ST_WAIT: begin
                    if (wait_cnt_q == 4'd0) begin
                        state_q <= ST_RESP;
                        if (port_q == PORT_D) begin
                            d_ack_q   <= 1'b1;
                            d_rdata_q <= we_q ? '0 : bus.mem_rdata;
                        end else begin
                            i_ack_q   <= 1'b1;
                            i_rdata_q <= bus.mem_rdata;
                        end
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 4'd1;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = busy_q;
    assign bus.i_ack     = i_ack_q;
    assign bus.i_err     = i_err_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.d_err     = d_err_q;
    assign bus.d_rdata   = d_rdata_q;

endmodule
